// File: rtl/sr_sched_pkg.sv
// Shared types and default sizes for the SR flag scheduler.
package sr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sched_state_t;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_NUM_FLAGS    = 8;
  localparam int unsigned DEF_PULSE_CYCLES = 2;
  localparam int unsigned DEF_GAP_CYCLES   = 1;

  // Wide enough for any practical bank; the top narrows it back to IDX_W.
  localparam int unsigned MAX_IDX_W = 8;

  typedef struct packed {
    logic                 set;
    logic [MAX_IDX_W-1:0] idx;
  } cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins, searching upward with wrap.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned PTR_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               any_grant
);

  logic [PTR_W-1:0] j;

  always_comb begin
    gnt       = '0;
    any_grant = 1'b0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = PTR_W'((32'(ptr) + 32'(k)) % NUM_REQ);
      if (!any_grant && req[j]) begin
        gnt[j]    = 1'b1;
        any_grant = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_flag_scheduler.sv
// Sequences one-at-a-time set/reset pulses into an SR latch bank and keeps a shadow of every flag.
module sr_flag_scheduler
  import sr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned NUM_FLAGS    = DEF_NUM_FLAGS,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  localparam int unsigned IDX_W = $clog2(NUM_FLAGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_set,
  input  logic [NUM_REQ*IDX_W-1:0] req_idx,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     clear_all,
  output logic                     clear_done,
  output logic [NUM_FLAGS-1:0]     S_o,
  output logic [NUM_FLAGS-1:0]     R_o,
  output logic [NUM_FLAGS-1:0]     flag_q,
  output logic                     busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned MAX_C = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W = $clog2(MAX_C + 1);

  sched_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_FLAGS-1:0]  s_d, r_d, flag_d;
  logic                  done_d;
  cmd_t                  cmd_q, cmd_d;
  logic                  clr_q, clr_d;

  logic [NUM_REQ-1:0]    gnt;
  logic                  any_grant;
  logic [PTR_W-1:0]      win;
  logic                  win_set;
  logic [IDX_W-1:0]      win_idx;
  logic [NUM_FLAGS-1:0]  win_mask, upd_mask;
  logic                  win_eff;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .any_grant (any_grant)
  );

  always_comb begin
    win     = '0;
    win_set = 1'b0;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win     = PTR_W'(i);
        win_set = req_set[i];
        win_idx = req_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  // Out-of-range or redundant commands are consumed without a pulse.
  assign win_mask = NUM_FLAGS'(1) << win_idx;
  assign win_eff  = (32'(win_idx) < NUM_FLAGS) && (win_set != (|(flag_q & win_mask)));
  assign upd_mask = NUM_FLAGS'(1) << cmd_q.idx;

  assign busy      = (state_q != IDLE);
  assign req_ready = (state_q == IDLE && !clear_all) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    s_d     = S_o;
    r_d     = R_o;
    flag_d  = flag_q;
    done_d  = 1'b0;
    cmd_d   = cmd_q;
    clr_d   = clr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_all) begin
          if (flag_q == '0) begin
            done_d = 1'b1;
          end else begin
            r_d     = flag_q;
            clr_d   = 1'b1;
            cnt_d   = CNT_W'(PULSE_CYCLES - 1);
            state_d = PULSE;
          end
        end else if (any_grant) begin
          ptr_d = (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
          if (win_eff) begin
            cmd_d.set = win_set;
            cmd_d.idx = MAX_IDX_W'(win_idx);
            clr_d     = 1'b0;
            cnt_d     = CNT_W'(PULSE_CYCLES - 1);
            state_d   = PULSE;
            if (win_set) s_d = win_mask;
            else         r_d = win_mask;
          end
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          s_d     = '0;
          r_d     = '0;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
          if (clr_q)          flag_d = '0;
          else if (cmd_q.set) flag_d = flag_q | upd_mask;
          else                flag_d = flag_q & ~upd_mask;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          done_d  = clr_q;
          clr_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      S_o        <= '0;
      R_o        <= '0;
      flag_q     <= '0;
      clear_done <= 1'b0;
      cmd_q      <= '0;
      clr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      S_o        <= s_d;
      R_o        <= r_d;
      flag_q     <= flag_d;
      clear_done <= done_d;
      cmd_q      <= cmd_d;
      clr_q      <= clr_d;
    end
  end

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// Bench for sr_flag_scheduler: timeline reference model checked every cycle, plus directed literals.
module tb_sr_flag_scheduler;

  localparam int NR = 4;
  localparam int NF = 8;
  localparam int IW = 3;
  localparam int P  = 2;
  localparam int G  = 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_set = '0;
  logic [NR*IW-1:0] req_idx = '0;
  logic           clear_all = 1'b0;
  logic [NR-1:0]  req_ready;
  logic           clear_done;
  logic [NF-1:0]  S_o, R_o, flag_q;
  logic           busy;

  sr_flag_scheduler #(
    .NUM_REQ      (NR),
    .NUM_FLAGS    (NF),
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_set    (req_set),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .clear_all  (clear_all),
    .clear_done (clear_done),
    .S_o        (S_o),
    .R_o        (R_o),
    .flag_q     (flag_q),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int mode = 0;   // 0 directed, 1 refill-and-toggle, 2 random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: an accepted effective command occupies cycles [ps, ps+P) with its pulse,
  // the flag changes at ps+P, and the scheduler is free again at idle_at = ps+P+G.
  int            m_ptr = 0;
  logic [NF-1:0] m_flags = '0;
  logic [NF-1:0] m_mask = '0;
  bit            m_set = 1'b0;
  bit            m_clr = 1'b0;
  int            ps = -1000;
  int            idle_at = 0;
  int            done_at = -1;
  logic [NR-1:0] acc_mask = '0;
  bit            acc_clr = 1'b0;
  int            glog[$];

  logic [NF-1:0] s_e, r_e;
  logic [NR-1:0] rdy_e;
  bit            busy_e, in_p;
  int            w, jj;
  logic [IW-1:0] c_idx;
  bit            c_set;

  initial forever begin
    @(negedge clk);
    acc_mask = '0;
    acc_clr  = 1'b0;
    if (!rst_n) begin
      m_ptr = 0; m_flags = '0; m_clr = 1'b0; ps = -1000; idle_at = cyc; done_at = -1;
      chk("reset_outputs", {2'b00, S_o, R_o, flag_q, req_ready, clear_done, busy}, 32'd0);
    end else begin
      if (cyc == ps + P)
        m_flags = m_clr ? '0 : (m_set ? (m_flags | m_mask) : (m_flags & ~m_mask));
      busy_e = (cyc < idle_at);
      in_p   = (cyc >= ps) && (cyc < ps + P);
      s_e    = (in_p && !m_clr && m_set) ? m_mask : '0;
      r_e    = (in_p && (m_clr || !m_set)) ? m_mask : '0;
      rdy_e  = '0;
      w      = -1;
      if (!busy_e && !clear_all)
        for (int k = 0; k < NR; k++) begin
          jj = (m_ptr + k) % NR;
          if (w < 0 && req_valid[jj]) w = jj;
        end
      if (w >= 0) rdy_e[w] = 1'b1;
      chk("S_o", S_o, s_e);
      chk("R_o", R_o, r_e);
      chk("flag_q", flag_q, m_flags);
      chk("busy", busy, busy_e);
      chk("clear_done", clear_done, (cyc == done_at));
      chk("req_ready", req_ready, rdy_e);
      chk("s_and_r_zero", S_o & R_o, 0);
      chk("ready_onehot", ($countones(req_ready) <= 1), 1);
      chk("ready_when_busy", (busy && req_ready != '0), 0);
      for (int i = 0; i < NR; i++) if (req_ready[i]) glog.push_back(i);
      if (!busy_e) begin
        if (clear_all) begin
          acc_clr = 1'b1;
          if (m_flags == '0) done_at = cyc + 1;
          else begin
            m_clr = 1'b1; m_mask = m_flags; ps = cyc + 1;
            idle_at = cyc + 1 + P + G; done_at = idle_at;
          end
        end else if (w >= 0) begin
          acc_mask[w] = 1'b1;
          m_ptr = (w + 1) % NR;
          c_idx = req_idx[w*IW +: IW];
          c_set = req_set[w];
          if (c_set != m_flags[c_idx]) begin
            m_clr = 1'b0; m_set = c_set; m_mask = '0; m_mask[c_idx] = 1'b1;
            ps = cyc + 1; idle_at = cyc + 1 + P + G;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc_mask[i]) begin
        if (mode == 1) req_set[i] = ~req_set[i];
        else           req_valid[i] = 1'b0;
      end
    if (acc_clr) clear_all = 1'b0;
    if (mode == 2) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_set[i]   = 1'($urandom_range(0, 1));
          req_idx[i*IW +: IW] = IW'($urandom_range(0, NF - 1));
        end
      if (!clear_all && $urandom_range(0, 40) == 0) clear_all = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    tick();
    while (busy && n < 40) begin
      tick();
      n++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic drive(input int r, input bit st, input int idx);
    req_valid[r] = 1'b1;
    req_set[r]   = st;
    req_idx[r*IW +: IW] = IW'(idx);
  endtask

  task automatic issue(input int r, input bit st, input int idx);
    tick();
    drive(r, st, idx);
    wait_idle();
  endtask

  int base;
  int n;
  int set_bits[5] = '{3, 0, 2, 5, 7};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_flags", flag_q, 8'h00);

    // Single set: req 0 sets idx 3.
    tick();
    drive(0, 1'b1, 3);
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick(); chk("t1_s_c1", S_o, 8'h08);
    tick(); chk("t1_s_c2", S_o, 8'h08); chk("t1_flag_c2", flag_q, 8'h00);
    tick(); chk("t1_s_c3", S_o, 8'h00); chk("t1_flag_c3", flag_q, 8'h08); chk("t1_busy_gap", busy, 1);
    tick(); chk("t1_idle_c4", busy, 0);

    // Redundant set then effective reset of idx 5.
    issue(1, 1'b1, 5);
    tick();
    drive(2, 1'b1, 5);
    #1 chk("t3_redundant_ready", req_ready, 4'b0100);
    tick(); chk("t3_redundant_s", S_o, 8'h00); chk("t3_redundant_busy", busy, 0);
    drive(3, 1'b0, 5);
    #1 chk("t3_reset_ready", req_ready, 4'b1000);
    tick(); chk("t3_reset_r", R_o, 8'h20);
    wait_idle();
    chk("t3_flags", flag_q, 8'h08);

    // Build 8'hA5, then clear_all against a pending requester.
    issue(0, 1'b0, set_bits[0]);
    for (int i = 1; i < 5; i++) issue(0, 1'b1, set_bits[i]);
    chk("t4_flags_a5", flag_q, 8'hA5);
    tick();
    clear_all = 1'b1;
    drive(1, 1'b1, 1);
    #1 chk("t4_clear_wins", req_ready, 4'b0000);
    tick(); chk("t4_r_c1", R_o, 8'hA5);
    tick(); chk("t4_r_c2", R_o, 8'hA5); chk("t4_done_c2", clear_done, 0);
    tick(); chk("t4_flags_c3", flag_q, 8'h00); chk("t4_r_c3", R_o, 8'h00);
    tick(); chk("t4_done_c4", clear_done, 1); chk("t4_req1_granted", req_ready, 4'b0010);
    tick(); chk("t4_done_once", clear_done, 0);
    wait_idle();

    // Fairness after a fresh reset: all requesters continuously valid.
    tick(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    for (int i = 0; i < NR; i++) drive(i, 1'b1, i);
    mode = 1;
    base = glog.size();
    n = 0;
    while (glog.size() < base + 8 && n < 80) begin
      tick();
      n++;
    end
    mode = 0;
    req_valid = '0;
    if (glog.size() < base + 8) chk("t2_grant_timeout", 1, 0);
    else for (int k = 0; k < 8; k++) chk($sformatf("t2_grant_%0d", k), glog[base+k], k % NR);
    wait_idle();

    // Reset mid-pulse, after moving the pointer away from 0.
    tick();
    drive(1, 1'b1, 0);
    tick(); chk("t5_s_before", S_o, 8'h01);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_clear", {8'h00, S_o, R_o, 7'h00, busy}, 0);
    chk("t5_flags_async", flag_q, 8'h00);
    tick(); tick(); rst_n = 1'b1;
    tick(); chk("t5_busy", busy, 0); chk("t5_flags", flag_q, 8'h00);
    drive(2, 1'b1, 4);
    drive(0, 1'b1, 6);
    #1 chk("t5_ptr_zero", req_ready, 4'b0001);
    wait_idle();
    wait_idle();

    // Randomized traffic, every cycle checked against the model.
    mode = 2;
    repeat (3000) tick();
    mode = 0;
    req_valid = '0;
    clear_all = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
